// File: rtl/fsm_pkg.sv
// Shared types and golden next-state function for the 3-state fsm block
// and its response checker.
package fsm_pkg;

  // State encoding of the fsm block under check.
  typedef enum logic [1:0] {
    S0      = 2'd0,
    S1      = 2'd1,
    S2      = 2'd2,
    ILLEGAL = 2'd3
  } fsm_state_e;

  // Controller states of the response checker.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  // Golden next state: each state advances on its own input, otherwise holds.
  // The illegal encoding falls back to S0.
  function automatic logic [1:0] fsm_next(input logic [1:0] state,
                                          input logic       i0,
                                          input logic       i1,
                                          input logic       i2);
    logic [1:0] nxt;
    case (state)
      S0:      nxt = i0 ? S1 : S0;
      S1:      nxt = i1 ? S2 : S1;
      S2:      nxt = i2 ? S0 : S2;
      default: nxt = S0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fsm_model.sv
// Purely combinational golden next-state model of the fsm block.
// Reusable as a stimulus reference as well as inside the checker.
module fsm_model
  import fsm_pkg::*;
(
  input  logic [1:0] a,
  input  logic       i0,
  input  logic       i1,
  input  logic       i2,
  output logic [1:0] nxt
);

  // Next state straight from the shared package function.
  always_comb begin
    nxt = fsm_next(a, i0, i1, i2);
  end

endmodule

// File: rtl/fsm_checker.sv
// Response checker for the 3-state fsm block. Samples a/i0..i2/y on every
// enabled cycle, compares y against the golden model, counts samples and
// mismatches, captures the first mismatch and raises done/pass after
// NUM_CYCLES samples.
// Optional build macro: FSM_CHECKER_STOP_ON_ERR_EN -- when defined, the first
// mismatch ends the check window immediately.
module fsm_checker
  import fsm_pkg::*;
#(
  parameter int NUM_CYCLES = 11,
  parameter int CW         = 8,
  parameter int EW         = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          en,
  input  logic          i0,
  input  logic          i1,
  input  logic          i2,
  input  logic [1:0]    a,
  input  logic [1:0]    y,
  output logic [CW-1:0] cycles,
  output logic [EW-1:0] err_count,
  output logic [CW-1:0] first_err_cycle,
  output logic [1:0]    first_err_exp,
  output logic [1:0]    first_err_got,
  output logic          done,
  output logic          pass
);

  localparam logic [1:0]    ST_IDLE  = IDLE;
  localparam logic [1:0]    ST_RUN   = RUN;
  localparam logic [1:0]    ST_DONE  = DONE;
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CYCLES - 1);
  localparam logic [EW-1:0] ERR_MAX  = {EW{1'b1}};

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [1:0]    exp_s;
  logic          sample_s;
  logic          mis_s;
  logic          stop_s;
  logic          finish_s;
  logic [EW-1:0] err_nxt_s;
  logic [CW-1:0] cycles_r;
  logic [EW-1:0] err_count_r;
  logic [CW-1:0] first_err_cycle_r;
  logic [1:0]    first_err_exp_r;
  logic [1:0]    first_err_got_r;
  logic          done_r;
  logic          pass_r;

  fsm_model u_model (
    .a   (a),
    .i0  (i0),
    .i1  (i1),
    .i2  (i2),
    .nxt (exp_s)
  );

  // Sample qualification, compare and window-end detection.
  always_comb begin
    sample_s = en & ((state_r == ST_IDLE) | (state_r == ST_RUN));
    // Illegal current state is always an error; case-inequality makes an
    // unknown y count as a mismatch in simulation.
    mis_s    = (a == 2'd3) | (y !== exp_s);
`ifdef FSM_CHECKER_STOP_ON_ERR_EN
    stop_s   = mis_s;
`else
    stop_s   = 1'b0;
`endif
    finish_s = sample_s & ((cycles_r == LAST_IDX) | stop_s);
  end

  // Saturating error count after the current sample.
  always_comb begin
    if (sample_s && mis_s && (err_count_r != ERR_MAX)) begin
      err_nxt_s = err_count_r + EW'(1);
    end else begin
      err_nxt_s = err_count_r;
    end
  end

  // Controller next state; disabled cycles in RUN simply hold.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (sample_s) begin
          state_nxt_s = finish_s ? ST_DONE : ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (finish_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_DONE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Sample and error counters, updated on every sampling edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycles_r    <= {CW{1'b0}};
      err_count_r <= {EW{1'b0}};
    end else if (sample_s) begin
      cycles_r    <= cycles_r + CW'(1);
      err_count_r <= err_nxt_s;
    end
  end

  // First-mismatch capture; loads once, then holds until reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      first_err_cycle_r <= {CW{1'b0}};
      first_err_exp_r   <= 2'd0;
      first_err_got_r   <= 2'd0;
    end else if (sample_s && mis_s && (err_count_r == {EW{1'b0}})) begin
      first_err_cycle_r <= cycles_r;
      first_err_exp_r   <= exp_s;
      first_err_got_r   <= y;
    end
  end

  // Sticky done and pass verdict, both set on the window-closing edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_r <= 1'b0;
      pass_r <= 1'b0;
    end else if (finish_s) begin
      done_r <= 1'b1;
      pass_r <= (err_nxt_s == {EW{1'b0}});
    end
  end

  assign cycles          = cycles_r;
  assign err_count       = err_count_r;
  assign first_err_cycle = first_err_cycle_r;
  assign first_err_exp   = first_err_exp_r;
  assign first_err_got   = first_err_got_r;
  assign done            = done_r;
  assign pass            = pass_r;

endmodule

// File: tb/tb_fsm_checker.sv
// Self-checking bench for fsm_checker: two instances (11- and 25-sample
// windows) share one randomized stimulus stream and are compared against a
// sample-level reference model every cycle.
module tb_fsm_checker;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en    = 1'b0;
  logic       i0    = 1'b0;
  logic       i1    = 1'b0;
  logic       i2    = 1'b0;
  logic [1:0] a     = 2'd0;
  logic [1:0] y     = 2'd0;

  logic [7:0] cyc_w [2];
  logic [3:0] err_w [2];
  logic [7:0] fec_w [2];
  logic [1:0] fee_w [2];
  logic [1:0] feg_w [2];
  logic       done_w[2];
  logic       pass_w[2];

  int n_chk = 0;
  int n_err = 0;

  int lim[2] = '{11, 25};
  int m_cyc[2];
  int m_err[2];
  int m_fc[2];
  int m_fe[2];
  int m_fg[2];
  bit m_done[2];

`ifdef FSM_CHECKER_STOP_ON_ERR_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  always #5 clock = ~clock;

  fsm_checker #(.NUM_CYCLES(11), .CW(8), .EW(4)) u_dut (
    .clock(clock), .reset(reset), .en(en), .i0(i0), .i1(i1), .i2(i2),
    .a(a), .y(y), .cycles(cyc_w[0]), .err_count(err_w[0]),
    .first_err_cycle(fec_w[0]), .first_err_exp(fee_w[0]),
    .first_err_got(feg_w[0]), .done(done_w[0]), .pass(pass_w[0])
  );

  fsm_checker #(.NUM_CYCLES(25), .CW(8), .EW(4)) u_sat (
    .clock(clock), .reset(reset), .en(en), .i0(i0), .i1(i1), .i2(i2),
    .a(a), .y(y), .cycles(cyc_w[1]), .err_count(err_w[1]),
    .first_err_cycle(fec_w[1]), .first_err_exp(fee_w[1]),
    .first_err_got(feg_w[1]), .done(done_w[1]), .pass(pass_w[1])
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference next state: state k advances to (k+1) mod 3 when input k is set.
  function automatic int gold(input int s, input bit j0, input bit j1, input bit j2);
    bit go;
    if (s == 3) return 0;
    go = (s == 0) ? j0 : ((s == 1) ? j1 : j2);
    return go ? (s + 1) % 3 : s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cyc[k] = 0; m_err[k] = 0; m_fc[k] = 0;
      m_fe[k] = 0;  m_fg[k] = 0;  m_done[k] = 1'b0;
    end
  endtask

  task automatic model_sample();
    int  e;
    bit  mis;
    e   = gold(int'(a), i0, i1, i2);
    mis = (a == 2'd3) || (int'(y) != e);
    for (int k = 0; k < 2; k++) begin
      if (en && !m_done[k]) begin
        if (mis && m_err[k] == 0) begin
          m_fc[k] = m_cyc[k] % 256;
          m_fe[k] = e;
          m_fg[k] = int'(y);
        end
        if (mis && m_err[k] < 15) m_err[k]++;
        m_cyc[k]++;
        if (m_cyc[k] == lim[k] || (STOP && mis)) m_done[k] = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.cycles[%0d]", tag, k), int'(cyc_w[k]), m_cyc[k] % 256);
      chk($sformatf("%s.err_count[%0d]", tag, k), int'(err_w[k]), m_err[k]);
      chk($sformatf("%s.first_err_cycle[%0d]", tag, k), int'(fec_w[k]), m_fc[k]);
      chk($sformatf("%s.first_err_exp[%0d]", tag, k), int'(fee_w[k]), m_fe[k]);
      chk($sformatf("%s.first_err_got[%0d]", tag, k), int'(feg_w[k]), m_fg[k]);
      chk($sformatf("%s.done[%0d]", tag, k), int'(done_w[k]), int'(m_done[k]));
      chk($sformatf("%s.pass[%0d]", tag, k), int'(pass_w[k]),
          int'(m_done[k] && m_err[k] == 0));
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, check at the next one.
  task automatic step(input string tag, input bit e, input int av,
                      input bit j0, input bit j1, input bit j2, input int yv);
    en = e; a = av[1:0]; i0 = j0; i1 = j1; i2 = j2; y = yv[1:0];
    @(posedge clock);
    model_sample();
    @(negedge clock);
    check_all(tag);
  endtask

  // Asynchronous reset taken between edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Feedback run: a follows the golden sequence, y optionally corrupted to 3
  // on one sample index.
  task automatic run_fb(input string tag, input int nsteps, input int bad_idx,
                        input bit rnd_i, input bit rnd_en);
    int cur = 0;
    int idx = 0;
    for (int n = 0; n < nsteps; n++) begin
      bit e, j0, j1, j2;
      int g, yv;
      e  = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      j0 = rnd_i ? 1'($urandom_range(0, 1)) : 1'b1;
      j1 = rnd_i ? 1'($urandom_range(0, 1)) : 1'b1;
      j2 = rnd_i ? 1'($urandom_range(0, 1)) : 1'b1;
      g  = gold(cur, j0, j1, j2);
      yv = (e && idx == bad_idx) ? 3 : g;
      step(tag, e, cur, j0, j1, j2, yv);
      if (e) begin
        cur = g;
        idx++;
      end
    end
  endtask

  initial begin
    #2;
    model_reset();
    check_all("por");
    @(negedge clock);
    reset = 1'b1;

    // Idle with en low: nothing counted, no done.
    for (int n = 0; n < 16; n++) step("idle", 1'b0, 0, 1'b1, 1'b1, 1'b1, 1);

    // Correct DUT, all inputs high, y sequence 1,2,0,...
    run_fb("clean", 14, -1, 1'b0, 1'b0);
    chk("clean.pass_dut", int'(pass_w[0]), 1);
    chk("clean.cycles_dut", int'(cyc_w[0]), 11);

    // Single corruption at sample index 4.
    do_reset("rst1");
    run_fb("corrupt", 14, 4, 1'b0, 1'b0);
    chk("corrupt.fec", int'(fec_w[0]), 4);
    chk("corrupt.fee", int'(fee_w[0]), 2);
    chk("corrupt.feg", int'(feg_w[0]), 3);
    chk("corrupt.pass", int'(pass_w[0]), 0);

    // Twenty consecutive mismatches into the 25-sample instance.
    do_reset("rst2");
    for (int n = 0; n < 27; n++) begin
      int av, g;
      bit j0, j1, j2;
      av = $urandom_range(0, 2);
      j0 = 1'($urandom_range(0, 1)); j1 = 1'($urandom_range(0, 1)); j2 = 1'($urandom_range(0, 1));
      g  = gold(av, j0, j1, j2);
      step("sat", 1'b1, av, j0, j1, j2, (n < 20) ? (g ^ 1) : g);
    end
`ifndef FSM_CHECKER_STOP_ON_ERR_EN
    chk("sat.err_count", int'(err_w[1]), 15);
    chk("sat.fec", int'(fec_w[1]), 0);
    chk("sat.done", int'(done_w[1]), 1);
`endif

    // Reset in the middle of a run, then a clean restart with gaps in en.
    do_reset("rst3");
    run_fb("pre_mid", 6, -1, 1'b1, 1'b0);
    do_reset("mid_rst");
    run_fb("restart", 40, -1, 1'b1, 1'b1);
    chk("restart.pass", int'(pass_w[0]), 1);

`ifdef FSM_CHECKER_STOP_ON_ERR_EN
    // Early stop: mismatch at index 2 ends the window at once.
    do_reset("rst_stop");
    run_fb("stop", 8, 2, 1'b0, 1'b0);
    chk("stop.cycles", int'(cyc_w[0]), 3);
    chk("stop.err", int'(err_w[0]), 1);
    chk("stop.done", int'(done_w[0]), 1);
`endif

    // Fully random traffic including illegal states and random errors.
    for (int r = 0; r < 4; r++) begin
      do_reset("rst_rnd");
      for (int n = 0; n < 35; n++) begin
        int av, g, yv;
        bit e, j0, j1, j2;
        e  = ($urandom_range(0, 4) != 0);
        av = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
        j0 = 1'($urandom_range(0, 1)); j1 = 1'($urandom_range(0, 1)); j2 = 1'($urandom_range(0, 1));
        g  = gold(av, j0, j1, j2);
        yv = ($urandom_range(0, 99) < 8 * r) ? $urandom_range(0, 3) : g;
        step("rand", e, av, j0, j1, j2, yv);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fsm_checker.md
Name: fsm_checker

Overview:
- Synthesizable response checker for the 3-state `fsm` block.
- Sits on the DUT's output side, opposite the stimulus driver.
- Each enabled cycle it samples the driven state `a`, inputs `i0..i2` and the DUT result `y`, then compares `y` against a golden next-state model.
- Counts cycles and errors, captures the first mismatch, and raises `done`/`pass` after a fixed number of samples, so hardware runs need no `$display` scraping.

Parameters:
- NUM_CYCLES, 11, samples checked before done (matches the 0..10 bench window).
- CW, 8, cycle counter width.
- EW, 4, error counter width (saturating).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- en  in  1  sample valid; high when the driver is out of its own reset
- i0  in  1  DUT input i0, as driven
- i1  in  1  DUT input i1, as driven
- i2  in  1  DUT input i2, as driven
- a  in  2  DUT current-state input, as driven
- y  in  2  DUT next-state output under check
- cycles  out  CW  samples taken so far
- err_count  out  EW  mismatches, saturating at 2^EW-1
- first_err_cycle  out  CW  cycles value at first mismatch
- first_err_exp  out  2  expected y at first mismatch
- first_err_got  out  2  observed y at first mismatch
- done  out  1  check window finished, sticky
- pass  out  1  done and err_count==0

Behaviour:
- Golden model, combinational `exp = next(a,i0,i1,i2)`:
  - S0(0): i0 -> S1, else S0
  - S1(1): i1 -> S2, else S1
  - S2(2): i2 -> S0, else S2
  - a==3 (illegal) -> exp=0; the sample also counts as a mismatch whatever y is.
- Controller FSM, states IDLE, RUN, DONE:
  - IDLE: on en=1, sample and go to RUN.
  - RUN: sample every cycle with en=1.
  - RUN: cycles with en=0 are skipped. They are not counted, state is held, and the machine does not return to IDLE.
  - RUN -> DONE on the clock edge that takes sample number NUM_CYCLES. That sample is fully compared and counted.
  - DONE: absorbing, with all outputs frozen. Leave only via reset.
- Per-sample timing:
  - cycles increments, wrapping at 2^CW.
  - The compare result is registered in the same edge: err_count and capture registers update on the edge that samples. Compare-to-output latency is 1 clock.
- First-error capture:
  - Loads only when err_count==0 and a mismatch occurs.
  - Holds afterwards.
  - first_err_cycle takes the cycles value before the increment, so the first sample is index 0.
- err_count saturates and never wraps.
- done and pass are registered. pass = done & (err_count==0), valid from the same cycle done rises.
- Reset (async, any time, including mid-RUN):
  - state = IDLE.
  - cycles, err_count and first_err_* = 0.
  - done = 0, pass = 0.
  - Deassertion is used directly, with no internal synchronizer; the integrator supplies it synchronous to clock.
- y=X/Z is treated as a mismatch in simulation only (case-inequality); synthesis ignores this.

Optional Feature:
- Macro: FSM_CHECKER_STOP_ON_ERR_EN.
- Defined: the first mismatch moves RUN -> DONE on that sampling edge. done=1 and pass=0 the next cycle, and err_count stays at 1.
- Undefined: the full NUM_CYCLES window runs regardless of errors.

Decomposition:
- Package `fsm_pkg`:
  - state typedef (S0=2'd0, S1=2'd1, S2=2'd2, ILLEGAL=2'd3)
  - checker state typedef (IDLE, RUN, DONE)
  - function `fsm_next(state,i0,i1,i2)`
- Sub-module `fsm_model`: purely combinational golden next-state, wrapping `fsm_next`.
- Sub-module reuse: the same `fsm_model` is reusable as a stimulus reference elsewhere.

Test Plan:
- Hold en=0 for 16 cycles with reset released -> state IDLE, cycles=0, done=0.
- Correct DUT, i0=i1=i2=1, a fed back from y starting at a=0, NUM_CYCLES=11 -> y sequence 1,2,0,1,2,0,... ; done rises the cycle after the 11th sample; cycles=11, err_count=0, pass=1.
- Corrupt y to 3 on sample index 4 -> err_count=1, first_err_cycle=4, first_err_exp=2, first_err_got=3, pass=0.
- Force 20 consecutive mismatches with EW=4 and NUM_CYCLES=25 -> err_count saturates at 15, first_err_* keeps the first capture.
- Assert reset mid-RUN at sample 6, then restart -> all outputs 0 immediately (asynchronous), new run counts from 0 and passes.
- Build with FSM_CHECKER_STOP_ON_ERR_EN and inject a mismatch at index 2 -> done=1 on the next cycle, cycles=3, err_count=1, pass=0, outputs frozen afterwards.
